// File: rtl/pw_pkg.sv
// pw_pkg: shared definitions for the pointwise weight tile streamer.
//   - controller state encoding
//   - beat geometry (16 weight bytes per 128-bit beat)
//   - beat count derivation and beat -> (lane, cin base) mapping helpers
package pw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_FETCH   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_WAIT_LD = 3'd4
  } pw_state_t;

  localparam int BEAT_BYTES      = 16;
  localparam int BEAT_W          = 8 * BEAT_BYTES;
  localparam int MAX_OUTSTANDING = 2;

  function automatic int nbeats(input int lanes, input int kt);
    return (lanes * kt) / BEAT_BYTES;
  endfunction

  function automatic int beats_per_lane(input int kt);
    return kt / BEAT_BYTES;
  endfunction

  // Beats are cin-fast: consecutive beats walk the cin axis of one lane.
  function automatic int beat_lane(input int n, input int kt);
    return n / beats_per_lane(kt);
  endfunction

  function automatic int beat_cin_base(input int n, input int kt);
    return (n % beats_per_lane(kt)) * BEAT_BYTES;
  endfunction

endpackage

// File: rtl/pw_weight_tile_streamer_if.sv
// pw_weight_tile_streamer_if: weight-memory read port.
//   mem_req/mem_addr  request, taken when mem_req && mem_gnt
//   mem_gnt           grant from memory
//   mem_rvalid/rdata  one in-order response per granted request
// master = streamer side, slave = memory side.
interface pw_weight_tile_streamer_if
  import pw_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [BEAT_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/pw_wstream_ctr.sv
// pw_wstream_ctr: issue/return counters for one tile transfer.
//   clear         zero both counters (transfer accepted)
//   issue         one request granted this cycle
//   ret           one response accepted this cycle
//   issued        requests granted so far
//   returned      responses accepted so far
//   can_issue     more beats to request and fewer than MAX_OUTSTANDING in flight
//   all_returned  every beat of the tile has come back
module pw_wstream_ctr
  import pw_pkg::*;
#(
  parameter int NBEATS = 64,
  parameter int CNT_W  = $clog2(NBEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             issue,
  input  logic             ret,
  output logic [CNT_W-1:0] issued,
  output logic [CNT_W-1:0] returned,
  output logic             can_issue,
  output logic             all_returned
);

  logic [CNT_W-1:0] outstanding;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued   <= '0;
      returned <= '0;
    end else if (clear) begin
      issued   <= '0;
      returned <= '0;
    end else begin
      if (issue) issued   <= issued + 1'b1;
      if (ret)   returned <= returned + 1'b1;
    end
  end

  assign outstanding  = issued - returned;
  assign can_issue    = (issued < CNT_W'(NBEATS)) &&
                        (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign all_returned = (returned == CNT_W'(NBEATS));

endmodule

// File: rtl/pw_weight_tile_streamer.sv
// pw_weight_tile_streamer: fetches one LANES x KT weight tile from memory
// as NBEATS 128-bit beats and streams them into a tile buffer.
//   clk, rst_n       clock, async active-low reset
//   start            begin a transfer (IDLE only); base_addr sampled then
//   auto_commit      pulse bank_commit together with done
//   busy, done       not IDLE / one-cycle end-of-transfer pulse
//   mem              weight-memory read port (master)
//   load_start       one-cycle pulse opening the buffer load
//   w_valid, w_data  registered beat stream, no backpressure
//   w_done           one-cycle pulse after the last beat
//   load_done        buffer has absorbed the tile
//   bank_commit      buffer bank switch
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_START   | load_start pulse, no requests yet
// ST_FETCH   | issuing requests (<= 2 in flight), forwarding responses
// ST_FLUSH   | w_done pulse
// ST_WAIT_LD | waiting for load_done, then done/bank_commit
module pw_weight_tile_streamer
  import pw_pkg::*;
#(
  parameter int LANES  = 32,
  parameter int KT     = 32,
  parameter int ADDR_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        auto_commit,
  output logic                        busy,
  output logic                        done,
  pw_weight_tile_streamer_if.master   mem,
  output logic                        load_start,
  output logic                        w_valid,
  output logic [BEAT_W-1:0]           w_data,
  output logic                        w_done,
  input  logic                        load_done,
  output logic                        bank_commit
);

  localparam int NBEATS = nbeats(LANES, KT);
  localparam int CNT_W  = $clog2(NBEATS + 1);

  pw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  issued, returned;
  logic              can_issue, all_returned;
  logic              accept_start, issue, accept_rsp;
  logic              req_c;
  logic              w_valid_q;
  logic [BEAT_W-1:0] w_data_q;

  assign accept_start = (state_q == ST_IDLE) && start;
  assign issue        = req_c && mem.mem_gnt;
  // Responses only count while a tile is being fetched and not yet complete;
  // strays in IDLE or past the last beat are dropped.
  assign accept_rsp   = (state_q == ST_FETCH) && !all_returned && mem.mem_rvalid;

  pw_wstream_ctr #(
    .NBEATS (NBEATS),
    .CNT_W  (CNT_W)
  ) u_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept_start),
    .issue        (issue),
    .ret          (accept_rsp),
    .issued       (issued),
    .returned     (returned),
    .can_issue    (can_issue),
    .all_returned (all_returned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_valid_q <= accept_rsp;
      if (accept_start) base_q   <= base_addr;
      if (accept_rsp)   w_data_q <= mem.mem_rdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_c       = 1'b0;
    load_start  = 1'b0;
    w_done      = 1'b0;
    done        = 1'b0;
    bank_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_START;
      end
      ST_START: begin
        load_start = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        req_c = can_issue;
        // The last beat's w_valid is visible in this same cycle.
        if (all_returned) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_done  = 1'b1;
        state_d = ST_WAIT_LD;
      end
      ST_WAIT_LD: begin
        if (load_done) begin
          done        = 1'b1;
          bank_commit = auto_commit;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = (state_q != ST_IDLE);
  assign mem.mem_req  = req_c;
  // Address wraps modulo 2^ADDR_W.
  assign mem.mem_addr = base_q + ADDR_W'(issued);
  assign w_valid      = w_valid_q;
  assign w_data       = w_data_q;

endmodule

// File: tb/tb_pw_weight_tile_streamer.sv
module tb_pw_weight_tile_streamer;

  localparam int NB = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [15:0]  base_addr;
  logic         auto_commit;
  logic         busy, done;
  logic         load_start, w_valid, w_done, load_done, bank_commit;
  logic [127:0] w_data;

  pw_weight_tile_streamer_if #(.ADDR_W(16)) mem_if ();

  pw_weight_tile_streamer #(.LANES(32), .KT(32), .ADDR_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .auto_commit (auto_commit),
    .busy        (busy),
    .done        (done),
    .mem         (mem_if),
    .load_start  (load_start),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .w_done      (w_done),
    .load_done   (load_done),
    .bank_commit (bank_commit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [15:0] a, input int i);
    return a[7:0] ^ (a[15:8] + 8'(i * 29));
  endfunction

  function automatic logic [127:0] mem_word(input logic [15:0] a);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = mem_byte(a, i);
    return w;
  endfunction

  // memory model: grant (fixed or random), in-order responses after 1..lat_max cycles
  bit          rand_gnt = 1'b0;
  int          lat_max  = 1;
  logic [15:0] q_addr[$];
  int          q_due[$];

  initial begin
    int cyc;
    int last_due;
    int due;
    cyc = 0;
    last_due = 0;
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mem_if.mem_rvalid = 1'b0;
      end
      mem_if.mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        due = cyc + int'($urandom_range(1, lat_max));
        if (due <= last_due) due = last_due + 1;
        q_addr.push_back(mem_if.mem_addr);
        q_due.push_back(due);
        last_due = due;
      end
    end
  end

  // monitor: sampled mid-cycle after all drivers settle
  int ls_total = 0, wv_total = 0, wd_total = 0, done_total = 0, commit_total = 0;
  int hs_total = 0, rv_total = 0, max_out = 0;
  int beat_idx = 0, hs_idx = 0;
  int early_err = 0, overlap_err = 0;
  bit seen_ls = 1'b0;
  logic [127:0] obs[NB];
  logic [15:0]  hs_addr[NB];

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) seen_ls = 1'b0;
      if (load_start) begin
        ls_total++;
        beat_idx = 0;
        hs_idx   = 0;
        seen_ls  = 1'b1;
      end
      if (mem_if.mem_req && mem_if.mem_gnt) begin
        if (hs_idx < NB) hs_addr[hs_idx] = mem_if.mem_addr;
        hs_idx++;
        hs_total++;
      end
      if (mem_if.mem_rvalid) rv_total++;
      if (hs_total - rv_total > max_out) max_out = hs_total - rv_total;
      if (w_valid) begin
        if (!seen_ls) early_err++;
        if (w_done) overlap_err++;
        if (beat_idx < NB) obs[beat_idx] = w_data;
        beat_idx++;
        wv_total++;
      end
      if (w_done) wd_total++;
      if (done) begin
        done_total++;
        seen_ls = 1'b0;
      end
      if (bank_commit) commit_total++;
    end
  end

  task automatic run_xfer(input logic [15:0] base, input bit auto, input bit hold);
    int ls0, wv0, wd0, dn0, cm0, n, errs;
    bit got;
    ls0 = ls_total; wv0 = wv_total; wd0 = wd_total; dn0 = done_total; cm0 = commit_total;
    @(negedge clk);
    base_addr   = base;
    auto_commit = auto;
    start       = 1'b1;
    @(negedge clk);
    base_addr = ~base;            // must already be latched
    if (!hold) start = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 3000) begin
      #1;
      if (w_done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("wdone_seen", got, 1);
    repeat (3) @(negedge clk);
    load_done = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 10) begin
      #1;
      if (done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    load_done = 1'b0;
    start     = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("busy_after", busy, 0);
    chk("load_start_cnt", ls_total - ls0, 1);
    chk("beat_cnt", wv_total - wv0, NB);
    chk("wdone_cnt", wd_total - wd0, 1);
    chk("done_cnt", done_total - dn0, 1);
    chk("commit_cnt", commit_total - cm0, auto ? 1 : 0);
    errs = 0;
    for (int i = 0; i < NB; i++) if (obs[i] !== mem_word(16'(base + 16'(i)))) errs++;
    chk("beat_data_errs", errs, 0);
    errs = 0;
    for (int i = 0; i < NB; i++) if (hs_addr[i] !== 16'(base + 16'(i))) errs++;
    chk("addr_seq_errs", errs, 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, mem_if.mem_req, 0);
    chk({tag, "_addr"}, mem_if.mem_addr, 0);
    chk({tag, "_ls"}, load_start, 0);
    chk({tag, "_wv"}, w_valid, 0);
    chk({tag, "_wdata"}, w_data, 0);
    chk({tag, "_wdone"}, w_done, 0);
    chk({tag, "_commit"}, bank_commit, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] wv;
    logic [15:0]  a;
    int n, wv_snap, wd_snap;
    bit got;
    rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; auto_commit = 1'b0; load_done = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1-cycle latency, grant always
    run_xfer(16'h0100, 1'b1, 1'b0);
    // lane L, cin k lives in beat L*2 + k/16, byte k%16
    for (int L = 0; L < 32; L += 13) begin
      a  = 16'(16'h0100 + 16'(L * 2));
      wv = obs[L * 2];
      chk($sformatf("map_lane%0d_k5", L), wv[8*5 +: 8], mem_byte(a, 5));
      wv = obs[L * 2 + 1];
      chk($sformatf("map_lane%0d_k21", L), wv[8*5 +: 8], mem_byte(16'(a + 16'd1), 5));
    end

    // random grant, 1-3 cycle latency, start held through done, no commit
    rand_gnt = 1'b1;
    lat_max  = 3;
    run_xfer(16'h0200, 1'b0, 1'b1);

    // address wrap
    run_xfer(16'hFFF0, 1'b1, 1'b0);
    chk("wrap_addr0", hs_addr[0], 16'hFFF0);
    chk("wrap_addr15", hs_addr[15], 16'hFFFF);
    chk("wrap_addr16", hs_addr[16], 16'h0000);
    chk("wrap_addr63", hs_addr[63], 16'h002F);

    // reset at beat 20
    @(negedge clk);
    base_addr = 16'h0400; auto_commit = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 1000) begin
      #1;
      if (beat_idx >= 20) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk("reach_beat20", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    wv_snap = wv_total;
    wd_snap = wd_total;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    chk("late_rsp_no_wv", wv_total - wv_snap, 0);
    chk("rst_no_wdone", wd_total - wd_snap, 0);
    chk("idle_after_rst", busy, 0);
    run_xfer(16'h0300, 1'b1, 1'b0);

    chk("max_outstanding_le2", (max_out <= 2), 1);
    chk("no_early_wvalid", early_err, 0);
    chk("no_wvalid_with_wdone", overlap_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
